// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lsu_pkg
// Purpose : Shared definitions for the load/store pipe: RISC-V funct3 size
//           codes, the completion record carried through the completion
//           queue, and the load alignment / extension helper.
// Rev     : 1.0  initial release
// ============================================================================
package lsu_pkg;

  localparam logic [2:0] LSU_F3_B  = 3'b000;
  localparam logic [2:0] LSU_F3_H  = 3'b001;
  localparam logic [2:0] LSU_F3_W  = 3'b010;
  localparam logic [2:0] LSU_F3_BU = 3'b100;
  localparam logic [2:0] LSU_F3_HU = 3'b101;

  // Completion record fields are sized for the widest supported tag and
  // register index; narrower configurations zero-extend into them.
  localparam int LSU_XLEN     = 32;
  localparam int LSU_PREG_MAX = 16;
  localparam int LSU_ROB_MAX  = 16;

  typedef struct packed {
    logic [LSU_XLEN-1:0]     data;
    logic [LSU_PREG_MAX-1:0] prd;
    logic [LSU_ROB_MAX-1:0]  rob_tag;
    logic                    is_store;
    logic                    exc;
  } lsu_cpl_t;

  // Select the addressed lane of a RAM word and sign/zero-extend it.
  // Halfwords look only at lane[1] and words ignore the lane, which gives
  // natural force-alignment for free. Unknown codes behave as LW.
  function automatic logic [31:0] lsu_align_load(input logic [31:0] word,
                                                 input logic [1:0]  lane,
                                                 input logic [2:0]  funct3);
    logic [7:0]  v_byte;
    logic [15:0] v_half;
    logic [31:0] v_res;
    v_byte = word[{lane, 3'b000} +: 8];
    v_half = lane[1] ? word[31:16] : word[15:0];
    case (funct3)
      LSU_F3_B:  v_res = {{24{v_byte[7]}}, v_byte};
      LSU_F3_BU: v_res = {24'h0, v_byte};
      LSU_F3_H:  v_res = {{16{v_half[15]}}, v_half};
      LSU_F3_HU: v_res = {16'h0, v_half};
      default:   v_res = word;
    endcase
    return v_res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_mem_pipe_cpl_fifo.sv
`default_nettype none
// ============================================================================
// Module  : lsu_cpl_fifo
// Purpose : Synchronous in-order FIFO of lsu_cpl_t completion records.
// Ports   : clk, reset (sync, active-high)
//           push / push_cpl  - enqueue one record
//           pop              - dequeue head (ignored when empty)
//           flush            - drop every entry
//           count            - current occupancy (0..DEPTH)
//           head             - oldest record (undefined when count == 0)
// Rev     : 1.0  initial release
// ============================================================================
module lsu_cpl_fifo
  import lsu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  lsu_cpl_t               push_cpl,
  input  logic                   pop,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output lsu_cpl_t               head
);

  localparam int PTR_W = $clog2(DEPTH);

  lsu_cpl_t         r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;
  logic             w_pop;

  assign w_pop = pop && (r_count != '0);

  // Storage carries no reset; occupancy alone says what is meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_wptr] <= push_cpl;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; full vs empty
  // is resolved by the occupancy counter.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign count = r_count;
  assign head  = r_mem[r_rptr];

endmodule
`default_nettype wire

// File: rtl/lsu_mem_pipe.sv
`default_nettype none
// ============================================================================
// Module  : lsu_mem_pipe
// Purpose : RV32 load/store unit with a local synchronous data RAM. Stores
//           write on the accept edge with byte enables; loads capture the RAM
//           word into S1, are aligned/extended, then enter an in-order
//           completion queue that absorbs CDB backpressure.
// Ports   : clk, reset (sync, active-high)
//           request : i_valid/o_ready, i_base_addr, i_offset, i_store_data,
//                     i_memwrite, i_funct3, i_prd, i_rob_tag
//           control : i_flush, i_stall
//           result  : o_valid, o_data, o_prd, o_rob_tag, o_is_store, o_exc
// Config  : LSU_MISALIGN_TRAP_EN - trap misaligned halfword/word accesses
//           (o_exc=1, store suppressed, load data 0); otherwise accesses are
//           force-aligned and o_exc is tied low.
// Rev     : 1.0  initial release
// ============================================================================
module lsu_mem_pipe
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ROB_WIDTH  = 4,
  parameter int PREG_WIDTH = 7,
  parameter int MEM_DEPTH  = 1024,
  parameter int OUTQ_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_base_addr,
  input  logic [DATA_WIDTH-1:0] i_offset,
  input  logic [DATA_WIDTH-1:0] i_store_data,
  input  logic                  i_memwrite,
  input  logic [2:0]            i_funct3,
  input  logic [PREG_WIDTH-1:0] i_prd,
  input  logic [ROB_WIDTH-1:0]  i_rob_tag,
  input  logic                  i_flush,
  input  logic                  i_stall,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [PREG_WIDTH-1:0] o_prd,
  output logic [ROB_WIDTH-1:0]  o_rob_tag,
  output logic                  o_is_store,
  output logic                  o_exc
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int CNT_W = $clog2(OUTQ_DEPTH) + 1;

  if (DATA_WIDTH != 32 || PREG_WIDTH > LSU_PREG_MAX || ROB_WIDTH > LSU_ROB_MAX ||
      OUTQ_DEPTH < 2 || (OUTQ_DEPTH & (OUTQ_DEPTH - 1)) != 0 ||
      (MEM_DEPTH & (MEM_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("lsu_mem_pipe: unsupported parameter combination");
  end

  // ---------------- address generation and access decode ----------------
  logic [31:0]      w_addr;
  logic [IDX_W-1:0] w_idx;
  logic [1:0]       w_lane;
  logic             w_accept;
  logic             w_sz_byte;
  logic             w_sz_half;
  logic             w_misalign;
  logic             w_we;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata;

  assign w_addr   = i_base_addr + i_offset;
  assign w_idx    = w_addr[IDX_W+1:2];
  assign w_lane   = w_addr[1:0];
  assign w_accept = i_valid && o_ready && !i_flush;

  // Store and load code spaces differ: 100/101 are sizes only for loads.
  assign w_sz_byte = (i_funct3 == LSU_F3_B) || (!i_memwrite && i_funct3 == LSU_F3_BU);
  assign w_sz_half = (i_funct3 == LSU_F3_H) || (!i_memwrite && i_funct3 == LSU_F3_HU);

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = (w_sz_half && w_lane[0]) ||
                      (!w_sz_byte && !w_sz_half && (w_lane != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_we = w_accept && i_memwrite && !w_misalign;

  // Replicate narrow store data across lanes so the byte enables alone
  // choose what lands in the RAM.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = i_store_data;
    if (w_sz_byte) begin
      w_be    = 4'b0001 << w_lane;
      w_wdata = {4{i_store_data[7:0]}};
    end else if (w_sz_half) begin
      w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{i_store_data[15:0]}};
    end
  end

  // ---------------- data RAM ----------------
  // Each word starts at i*4 in simulation via its declaration initialiser;
  // there is no reset on the array.
  logic [31:0] w_words [MEM_DEPTH];

  for (genvar gi = 0; gi < MEM_DEPTH; gi++) begin : g_word
    logic [31:0] r_word = 32'(gi * 4);
    always_ff @(posedge clk) begin
      if (w_we && (w_idx == IDX_W'(gi))) begin
        for (int b = 0; b < 4; b++) begin
          if (w_be[b]) r_word[8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end
    end
    assign w_words[gi] = r_word;
  end

  // ---------------- S1 ----------------
  logic                  r_s1_valid;
  logic [31:0]           r_s1_word;
  logic [1:0]            r_s1_lane;
  logic [2:0]            r_s1_f3;
  logic                  r_s1_store;
  logic                  r_s1_exc;
  logic [PREG_WIDTH-1:0] r_s1_prd;
  logic [ROB_WIDTH-1:0]  r_s1_tag;

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_s1_word  <= w_words[w_idx];
      r_s1_lane  <= w_lane;
      r_s1_f3    <= i_funct3;
      r_s1_store <= i_memwrite;
      r_s1_exc   <= w_misalign;
      r_s1_prd   <= i_prd;
      r_s1_tag   <= i_rob_tag;
    end
  end

  lsu_cpl_t w_cpl;

  always_comb begin
    w_cpl          = '0;
    w_cpl.rob_tag  = LSU_ROB_MAX'(r_s1_tag);
    w_cpl.is_store = r_s1_store;
    w_cpl.exc      = r_s1_exc;
    if (!r_s1_store) begin
      w_cpl.prd = LSU_PREG_MAX'(r_s1_prd);
      if (!r_s1_exc) w_cpl.data = lsu_align_load(r_s1_word, r_s1_lane, r_s1_f3);
    end
  end

  // ---------------- completion queue ----------------
  logic [CNT_W-1:0] w_count;
  lsu_cpl_t         w_head;

  lsu_cpl_fifo #(
    .DEPTH (OUTQ_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (r_s1_valid),
    .push_cpl (w_cpl),
    .pop      (o_valid && !i_stall),
    .flush    (i_flush),
    .count    (w_count),
    .head     (w_head)
  );

  // Admission counts the entry already in S1, so a request accepted now
  // always finds a slot even if the CDB stalls indefinitely. Registers only.
  assign o_ready = (w_count + CNT_W'(r_s1_valid)) < CNT_W'(OUTQ_DEPTH);

  // Head fields are gated so idle outputs read as zero.
  assign o_valid    = (w_count != '0);
  assign o_data     = o_valid ? w_head.data : '0;
  assign o_prd      = o_valid ? w_head.prd[PREG_WIDTH-1:0] : '0;
  assign o_rob_tag  = o_valid ? w_head.rob_tag[ROB_WIDTH-1:0] : '0;
  assign o_is_store = o_valid && w_head.is_store;
  assign o_exc      = o_valid && w_head.exc;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_lsu_mem_pipe
// Purpose : Directed self-checking bench for lsu_mem_pipe (default params).
// Rev     : 1.0  initial release
// ============================================================================
module tb_lsu_mem_pipe;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_base_addr;
  logic [31:0] i_offset;
  logic [31:0] i_store_data;
  logic        i_memwrite;
  logic [2:0]  i_funct3;
  logic [6:0]  i_prd;
  logic [3:0]  i_rob_tag;
  logic        i_flush;
  logic        i_stall;
  logic        o_valid;
  logic [31:0] o_data;
  logic [6:0]  o_prd;
  logic [3:0]  o_rob_tag;
  logic        o_is_store;
  logic        o_exc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_mem_pipe dut (
    .clk          (clk),
    .reset        (reset),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_base_addr  (i_base_addr),
    .i_offset     (i_offset),
    .i_store_data (i_store_data),
    .i_memwrite   (i_memwrite),
    .i_funct3     (i_funct3),
    .i_prd        (i_prd),
    .i_rob_tag    (i_rob_tag),
    .i_flush      (i_flush),
    .i_stall      (i_stall),
    .o_valid      (o_valid),
    .o_data       (o_data),
    .o_prd        (o_prd),
    .o_rob_tag    (o_rob_tag),
    .o_is_store   (o_is_store),
    .o_exc        (o_exc)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [2:0] f3, input logic [31:0] base,
                       input logic [31:0] off, input logic [31:0] sd,
                       input logic [6:0] prd, input logic [3:0] tag);
    i_valid = 1'b1; i_memwrite = st; i_funct3 = f3; i_base_addr = base;
    i_offset = off; i_store_data = sd; i_prd = prd; i_rob_tag = tag;
  endtask

  task automatic idle();
    i_valid = 1'b0; i_memwrite = 1'b0; i_funct3 = 3'b010; i_base_addr = '0;
    i_offset = '0; i_store_data = '0; i_prd = '0; i_rob_tag = '0;
  endtask

  // One isolated request, checked two edges after acceptance (no stall).
  task automatic single(input string name, input logic st, input logic [2:0] f3,
                        input logic [31:0] base, input logic [31:0] off,
                        input logic [31:0] sd, input logic [6:0] prd,
                        input logic [3:0] tag, input logic [31:0] exp_data,
                        input logic exp_exc);
    @(negedge clk);
    drive(st, f3, base, off, sd, prd, tag);
    chk({name, "/ready"}, 32'(o_ready), 32'd1);
    @(negedge clk);
    idle();
    chk({name, "/early_valid"}, 32'(o_valid), 32'd0);
    @(negedge clk);
    chk({name, "/valid"}, 32'(o_valid), 32'd1);
    chk({name, "/data"}, o_data, exp_data);
    chk({name, "/prd"}, 32'(o_prd), st ? 32'd0 : 32'(prd));
    chk({name, "/tag"}, 32'(o_rob_tag), 32'(tag));
    chk({name, "/is_store"}, 32'(o_is_store), 32'(st));
    chk({name, "/exc"}, 32'(o_exc), 32'(exp_exc));
  endtask

  initial begin
    int  nacc;
    int  ncpl;
    logic w_acc;

    reset = 1'b1; i_flush = 1'b0; i_stall = 1'b0;
    idle();
    repeat (3) @(negedge clk);
    chk("rst/valid", 32'(o_valid), 32'd0);
    chk("rst/ready", 32'(o_ready), 32'd1);
    chk("rst/data", o_data, 32'd0);
    chk("rst/prd", 32'(o_prd), 32'd0);
    chk("rst/tag", 32'(o_rob_tag), 32'd0);
    chk("rst/is_store", 32'(o_is_store), 32'd0);
    chk("rst/exc", 32'(o_exc), 32'd0);
    reset = 1'b0;

    // Basic load of the initial RAM image (word 5 = 0x14).
    single("lw_init", 1'b0, LSU_F3_W, 32'h10, 32'h4, 32'h0, 7'd5, 4'd3, 32'h14, 1'b0);
    // Negative offset and ignored upper address bits.
    single("lw_negoff", 1'b0, LSU_F3_W, 32'h30, 32'hFFFF_FFFC, 32'h0, 7'd6, 4'd4, 32'h2C, 1'b0);
    single("lw_hibits", 1'b0, LSU_F3_W, 32'h1000_0014, 32'h0, 32'h0, 7'd7, 4'd5, 32'h14, 1'b0);

    // Byte store then byte/word loads of word 8 (initially 0x20).
    single("sb", 1'b1, LSU_F3_B, 32'h20, 32'h1, 32'h1234_56AB, 7'd9, 4'd6, 32'h0, 1'b0);
    single("lbu", 1'b0, LSU_F3_BU, 32'h21, 32'h0, 32'h0, 7'd10, 4'd7, 32'h0000_00AB, 1'b0);
    single("lb", 1'b0, LSU_F3_B, 32'h21, 32'h0, 32'h0, 7'd11, 4'd8, 32'hFFFF_FFAB, 1'b0);
    single("lw_after_sb", 1'b0, LSU_F3_W, 32'h20, 32'h0, 32'h0, 7'd12, 4'd9, 32'h0000_AB20, 1'b0);

    // Halfword store into upper half of word 9 (0x24) then LH/LHU.
    single("sh", 1'b1, LSU_F3_H, 32'h26, 32'h0, 32'hFFFF_8001, 7'd1, 4'd10, 32'h0, 1'b0);
    single("lh", 1'b0, LSU_F3_H, 32'h26, 32'h0, 32'h0, 7'd13, 4'd11, 32'hFFFF_8001, 1'b0);
    single("lhu", 1'b0, LSU_F3_HU, 32'h26, 32'h0, 32'h0, 7'd14, 4'd12, 32'h0000_8001, 1'b0);
    single("lw_after_sh", 1'b0, LSU_F3_W, 32'h24, 32'h0, 32'h0, 7'd15, 4'd13, 32'h8001_0024, 1'b0);

    // Back-to-back store then load of the same word 28 (0x70).
    @(negedge clk);
    drive(1'b1, LSU_F3_W, 32'h70, 32'h0, 32'h1234_5678, 7'd0, 4'd1);
    @(negedge clk);
    drive(1'b0, LSU_F3_W, 32'h70, 32'h0, 32'h0, 7'd20, 4'd2);
    @(negedge clk);
    idle();
    chk("b2b/st_valid", 32'(o_valid), 32'd1);
    chk("b2b/st_store", 32'(o_is_store), 32'd1);
    chk("b2b/st_tag", 32'(o_rob_tag), 32'd1);
    @(negedge clk);
    chk("b2b/ld_valid", 32'(o_valid), 32'd1);
    chk("b2b/ld_tag", 32'(o_rob_tag), 32'd2);
    chk("b2b/ld_data", o_data, 32'h1234_5678);
    chk("b2b/ld_prd", 32'(o_prd), 32'd20);

    // Stall with six back-to-back loads: four fit, the rest wait.
    @(negedge clk);
    i_stall = 1'b1;
    nacc = 0;
    for (int c = 0; c < 8; c++) begin
      if (nacc < 6) drive(1'b0, LSU_F3_W, 32'h40 + 32'(4 * nacc), 32'h0, 32'h0, 7'(10 + nacc), 4'(8 + nacc));
      else idle();
      w_acc = (nacc < 6) && o_ready;
      @(negedge clk);
      if (w_acc) nacc++;
    end
    chk("stall/accepted", 32'(nacc), 32'd4);
    chk("stall/ready_low", 32'(o_ready), 32'd0);
    chk("stall/head_valid", 32'(o_valid), 32'd1);
    chk("stall/head_tag", 32'(o_rob_tag), 32'd8);
    @(negedge clk);
    chk("stall/head_held", 32'(o_rob_tag), 32'd8);
    chk("stall/head_data", o_data, 32'h40);

    // Release: drain in order while admitting the remaining two.
    i_stall = 1'b0;
    ncpl = 0;
    for (int c = 0; c < 40 && ncpl < 6; c++) begin
      if (nacc < 6) drive(1'b0, LSU_F3_W, 32'h40 + 32'(4 * nacc), 32'h0, 32'h0, 7'(10 + nacc), 4'(8 + nacc));
      else idle();
      w_acc = (nacc < 6) && o_ready;
      if (o_valid) begin
        chk("rel/tag", 32'(o_rob_tag), 32'(8 + ncpl));
        chk("rel/data", o_data, 32'h40 + 32'(4 * ncpl));
        chk("rel/prd", 32'(o_prd), 32'(10 + ncpl));
        ncpl++;
      end
      @(negedge clk);
      if (w_acc) nacc++;
    end
    idle();
    chk("rel/all_accepted", 32'(nacc), 32'd6);
    chk("rel/all_completed", 32'(ncpl), 32'd6);
    chk("rel/drained", 32'(o_valid), 32'd0);

    // Flush with three queued and one in S1.
    i_stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(1'b0, LSU_F3_W, 32'h80 + 32'(4 * k), 32'h0, 32'h0, 7'(1 + k), 4'(1 + k));
    end
    @(negedge clk);
    chk("flush/pre_ready", 32'(o_ready), 32'd0);
    chk("flush/pre_valid", 32'(o_valid), 32'd1);
    drive(1'b0, LSU_F3_W, 32'h14, 32'h0, 32'h0, 7'd3, 4'hF);
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    idle();
    chk("flush/valid", 32'(o_valid), 32'd0);
    chk("flush/ready", 32'(o_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("flush/ignored_req", 32'(o_valid), 32'd0);
    i_stall = 1'b0;
    single("flush/post_lw", 1'b0, LSU_F3_W, 32'h14, 32'h0, 32'h0, 7'd8, 4'd6, 32'h14, 1'b0);

    // Misaligned accesses around word 24 (0x60).
`ifdef LSU_MISALIGN_TRAP_EN
    single("mis/lw", 1'b0, LSU_F3_W, 32'h60, 32'h2, 32'h0, 7'd4, 4'd1, 32'h0, 1'b1);
    single("mis/lh", 1'b0, LSU_F3_H, 32'h61, 32'h0, 32'h0, 7'd4, 4'd2, 32'h0, 1'b1);
    single("mis/sw", 1'b1, LSU_F3_W, 32'h60, 32'h2, 32'h0000_DEAD, 7'd4, 4'd3, 32'h0, 1'b1);
    single("mis/lw_check", 1'b0, LSU_F3_W, 32'h60, 32'h0, 32'h0, 7'd4, 4'd4, 32'h60, 1'b0);
`else
    single("mis/lw", 1'b0, LSU_F3_W, 32'h60, 32'h2, 32'h0, 7'd4, 4'd1, 32'h60, 1'b0);
    single("mis/lh", 1'b0, LSU_F3_H, 32'h61, 32'h0, 32'h0, 7'd4, 4'd2, 32'h60, 1'b0);
    single("mis/sw", 1'b1, LSU_F3_W, 32'h60, 32'h2, 32'h0000_DEAD, 7'd4, 4'd3, 32'h0, 1'b0);
    single("mis/lw_check", 1'b0, LSU_F3_W, 32'h60, 32'h0, 32'h0, 7'd4, 4'd4, 32'h0000_DEAD, 1'b0);
`endif

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
